key_expand_seq: RTL and testbench
=================================

Name: key_expand_seq

Overview:
- Sequential AES-128 key expansion stage, directly upstream of the cipher round datapath.
- Loads a 128-bit cipher key and presents one 128-bit round key (Nk=4 words) per clock on wBlock, for round 0 through round 10.
- Emits a one-cycle done strobe with the round-10 key, so the downstream cipher completes in 11 cycles without stalls.

Parameters:
- NR, 10, number of AES rounds. Fixed for AES-128; other values are unsupported.

Ports:
- clk      input   1    system clock, rising-edge
- reset    input   1    synchronous, active-low reset
- start    input   1    begin expansion of key; sampled only in IDLE or DONE
- key      input   128  cipher key; key[127:96] = w0, byte 0 in the MSBs
- wBlock   output  128  current round key; wBlock[127:96] = w[4r]
- round    output  4    index r of the round key on wBlock (0..10)
- busy     output  1    high while in RUN
- done     output  1    one-cycle pulse, coincident with round==10 on wBlock

Behaviour:
- Reset (reset==0 at a clk edge) takes priority over all other inputs and applies in any state, including mid-run. Reset values:
  - state=IDLE, wBlock=0, round=0, busy=0, done=0.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1: at the next edge, wBlock<=key, round<=0, state<=RUN.
  - start=0: hold all outputs.
- RUN:
  - busy=1.
  - round<10: at each edge, wBlock<=next(wBlock, Rcon[round+1]) and round<=round+1.
  - round==10: done=1 (combinational from state and round); the next edge moves to DONE.
  - start is ignored in RUN.
- Latency: 1 cycle from start to round-0 key; round-r key is valid r+1 cycles after start; done occurs in the 11th RUN cycle.
- DONE:
  - busy=0, done=0; wBlock and round hold the round-10 key and 10.
  - start=1 restarts exactly as from IDLE; the new key is loaded at the next edge.
- next() is FIPS-197 KeyExpansion:
  - t = SubWord(RotWord(w3)) ^ {Rcon,24'h0}
  - w0'=w0^t, w1'=w1^w0', w2'=w2^w1', w3'=w3^w2'
  - The four words chain combinationally within one cycle.
- RotWord: {b1,b2,b3,b0}. SubWord: 4 parallel AES S-box lookups.
- Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36. Round is a 4-bit counter that never exceeds 10.
- The key input is sampled only on the start edge. Changes to key during RUN have no effect.
- Reset and start asserted in the same cycle: reset wins, the block goes to IDLE, and start is lost.

Optional Feature:
- Macro: KEYEXP_ROUNDKEY_STORE_EN.
- Defined:
  - Adds an 11-entry x 128-bit register file written with wBlock at index round on every RUN cycle.
  - Adds ports rd_addr (input, 4 bits) and rd_key (output, 128 bits). rd_key is a combinational read; addresses above 10 return 0.
  - The file is cleared on reset. It is not cleared on restart; entries are overwritten as the new expansion progresses.
  - Lets a later inverse cipher read round keys in reverse order without re-expanding.
- Undefined: no storage and no extra ports; behaviour is otherwise identical.

Test Plan:
- FIPS-197 A.1 key:
  - Stimulus: reset, then start=1 for one cycle with key=2b7e151628aed2a6abf7158809cf4f3c.
  - Response: the next cycle shows wBlock=key, round=0, busy=1. The following cycle shows wBlock=a0fafe1788542cb123a339392a6c7605, round=1. The 11th RUN cycle shows wBlock=d014f9a8c9ee2589e13f0cc8b6630ca6, round=10, done=1. Then DONE with busy=0, done=0, and wBlock held.
- Restart with all-zero key:
  - Stimulus: start=1 in DONE with key=0.
  - Response: round 1 = 62636363626363636263636362636363; round 10 = b4ef5bcb3e92e21123e951cf6f8f188e; exactly one done pulse.
- Start ignored in RUN:
  - Stimulus: pulse start at round 4 with a different key.
  - Response: the A.1 sequence continues unchanged and done fires at round 10.
- Reset mid-operation:
  - Stimulus: drive reset=0 for one cycle at round 6.
  - Response: the next cycle shows IDLE with wBlock=0, round=0, busy=0, done=0 and no done pulse. A subsequent start reproduces the full A.1 sequence.
- Reset/start collision:
  - Stimulus: reset=0 and start=1 in the same cycle.
  - Response: the block stays in IDLE with busy=0.
- With KEYEXP_ROUNDKEY_STORE_EN defined, after the A.1 run:
  - rd_addr=1 returns a0fafe17...7605.
  - rd_addr=10 returns d014f9a8...0ca6.
  - rd_addr=12 returns 0.

Source files
------------

// File: rtl/key_expand_seq.sv
// ============================================================================
// key_expand_seq : sequential AES-128 key expansion, one round key per clock.
// Optional round-key store enabled by KEYEXP_ROUNDKEY_STORE_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module key_expand_seq #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [127:0] key,
  output logic [127:0] wBlock,
  output logic [3:0]   round,
  output logic         busy,
  output logic         done
`ifdef KEYEXP_ROUNDKEY_STORE_EN
  ,
  input  logic [3:0]   rd_addr,
  output logic [127:0] rd_key
`endif
);

  localparam logic [3:0] LAST_ROUND = 4'(NR);

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         state_q;
  logic [127:0]   wblock_q, wblock_d;
  logic [3:0]     round_q, round_d;
  logic           busy_q, done_q;

  logic [31:0]    rot_w, sub_w, t_w;
  logic [31:0]    w0_d, w1_d, w2_d, w3_d;
  logic [7:0]     rcon_w;

  always_comb begin
    case (round_d)
      4'd1:    rcon_w = 8'h01;
      4'd2:    rcon_w = 8'h02;
      4'd3:    rcon_w = 8'h04;
      4'd4:    rcon_w = 8'h08;
      4'd5:    rcon_w = 8'h10;
      4'd6:    rcon_w = 8'h20;
      4'd7:    rcon_w = 8'h40;
      4'd8:    rcon_w = 8'h80;
      4'd9:    rcon_w = 8'h1b;
      4'd10:   rcon_w = 8'h36;
      default: rcon_w = 8'h00;
    endcase
  end

  // Next round key: all four words chain within a single cycle.
  always_comb begin
    round_d = round_q + 4'd1;
    rot_w   = {wblock_q[23:0], wblock_q[31:24]};
    sub_w   = '0;
    for (int i = 0; i < 4; i++) begin
      sub_w[8*i +: 8] = SBOX[rot_w[8*i +: 8]];
    end
    t_w      = sub_w ^ {rcon_w, 24'h0};
    w0_d     = wblock_q[127:96] ^ t_w;
    w1_d     = wblock_q[95:64]  ^ w0_d;
    w2_d     = wblock_q[63:32]  ^ w1_d;
    w3_d     = wblock_q[31:0]   ^ w2_d;
    wblock_d = {w0_d, w1_d, w2_d, w3_d};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      wblock_q <= '0;
      round_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_q  <= S_RUN;
            wblock_q <= key;
            round_q  <= '0;
            busy_q   <= 1'b1;
            done_q   <= 1'b0;
          end
        end
        S_RUN: begin
          if (round_q == LAST_ROUND) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
          end else begin
            wblock_q <= wblock_d;
            round_q  <= round_d;
            // Registered so the strobe lines up with the final round key.
            done_q   <= (round_d == LAST_ROUND);
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign wBlock = wblock_q;
  assign round  = round_q;
  assign busy   = busy_q;
  assign done   = done_q;

`ifdef KEYEXP_ROUNDKEY_STORE_EN
  logic [127:0] store_q [0:10];

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i <= 10; i++) begin
        store_q[i] <= '0;
      end
    end else if (state_q == S_RUN && round_q <= 4'd10) begin
      store_q[round_q] <= wblock_q;
    end
  end

  assign rd_key = (rd_addr <= 4'd10) ? store_q[rd_addr] : 128'h0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_key_expand_seq.sv
// Bench for key_expand_seq: scoreboard fed by a word-level FIPS-197 key schedule.
`default_nettype none

module tb_key_expand_seq;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [127:0] key = '0;
  logic [127:0] wBlock;
  logic [3:0]   round;
  logic         busy;
  logic         done;
`ifdef KEYEXP_ROUNDKEY_STORE_EN
  logic [3:0]   rd_addr = '0;
  logic [127:0] rd_key;
`endif

  key_expand_seq #(.NR(10)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .key    (key),
    .wBlock (wBlock),
    .round  (round),
    .busy   (busy),
    .done   (done)
`ifdef KEYEXP_ROUNDKEY_STORE_EN
    ,
    .rd_addr(rd_addr),
    .rd_key (rd_key)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] wb;
    logic [3:0]   rnd;
    logic         dn;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  bit          mon_en = 1'b0;
  logic [7:0]  sbox_m [256];

  localparam logic [127:0] A1_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] A1_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] A1_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] Z_R1   = 128'h62636363626363636263636362636363;
  localparam logic [127:0] Z_R10  = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = xtime(aa);
      bb = bb >> 1;
    end
    return p;
  endfunction

  // S-box derived from GF(2^8) inverse plus the affine transform.
  task automatic build_sbox();
    logic [7:0] inv, b;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      b = inv;
      sbox_m[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                    ^ {b[3:0], b[7:4]} ^ 8'h63;
    end
  endtask

  task automatic push_run(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0]  rc;
    exp_t        e;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sbox_m[tmp[31:24]], sbox_m[tmp[23:16]], sbox_m[tmp[15:8]], sbox_m[tmp[7:0]]};
        tmp = tmp ^ {rc, 24'h0};
        rc  = xtime(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r <= 10; r++) begin
      e.wb  = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      e.rnd = 4'(r);
      e.dn  = (r == 10);
      exp_q.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (busy === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got round %0d wBlock %h expected no output", round, wBlock);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("sb_wBlock", wBlock, e.wb);
          chk("sb_round", 128'(round), 128'(e.rnd));
          chk("sb_done", 128'(done), 128'(e.dn));
        end
      end else begin
        chk("idle_done_low", 128'(done), 128'(1'b0));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    key = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic start_run(input logic [127:0] k);
    push_run(k);
    start = 1'b1;
    key   = k;
    step();
    start = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_wBlock"}, wBlock, 128'h0);
    chk({tag, "_round"}, 128'(round), 128'h0);
    chk({tag, "_busy"}, 128'(busy), 128'h0);
    chk({tag, "_done"}, 128'(done), 128'h0);
  endtask

  initial begin
    int gap, inj;
    logic [127:0] rk;
    build_sbox();

    reset = 1'b0;
    repeat (2) step();
    reset = 1'b1;
    chk_reset_state("reset");
    mon_en = 1'b1;

    // Reset and start together: start must be lost.
    reset = 1'b0; start = 1'b1; key = A1_KEY;
    step();
    reset = 1'b1; start = 1'b0;
    chk_reset_state("collision");
    step();
    chk("collision_busy_after", 128'(busy), 128'h0);

    // FIPS-197 A.1 run with direct known-answer checks.
    start_run(A1_KEY);
    chk("a1_r0", wBlock, A1_KEY);
    chk("a1_r0_busy", 128'(busy), 128'h1);
    step();
    chk("a1_r1", wBlock, A1_R1);
    repeat (9) step();
    chk("a1_r10", wBlock, A1_R10);
    chk("a1_r10_done", 128'(done), 128'h1);
    step();
    chk("done_state_busy", 128'(busy), 128'h0);
    chk("done_state_wBlock", wBlock, A1_R10);
    chk("done_state_round", 128'(round), 128'd10);
    step();
    chk("done_hold_wBlock", wBlock, A1_R10);

`ifdef KEYEXP_ROUNDKEY_STORE_EN
    rd_addr = 4'd1;  #1 chk("store_rd1", rd_key, A1_R1);
    rd_addr = 4'd10; #1 chk("store_rd10", rd_key, A1_R10);
    rd_addr = 4'd12; #1 chk("store_rd12", rd_key, 128'h0);
`endif

    // Restart from DONE with an all-zero key.
    start_run(128'h0);
    step();
    chk("zero_r1", wBlock, Z_R1);
    repeat (9) step();
    chk("zero_r10", wBlock, Z_R10);
    step();

    // Start pulse during RUN is ignored.
    start_run(A1_KEY);
    repeat (4) step();
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (5) step();
    chk("ign_r10", wBlock, A1_R10);
    step();

    // Reset at round 6 aborts the run.
    start_run(A1_KEY);
    repeat (6) step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    exp_q.delete();
    chk_reset_state("midreset");
    step();
    start_run(A1_KEY);
    repeat (10) step();
    chk("after_reset_r10", wBlock, A1_R10);
    step();

    // Randomized runs with idle gaps and stray start pulses in RUN.
    for (int n = 0; n < 8; n++) begin
      rk  = {$urandom, $urandom, $urandom, $urandom};
      gap = $urandom_range(0, 3);
      inj = $urandom_range(0, 12);
      repeat (gap) step();
      start_run(rk);
      for (int r = 1; r <= 10; r++) begin
        start = (r == inj);
        step();
      end
      start = 1'b0;
      step();
    end

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
    chk("queue_drained", 128'(exp_q.size()), 128'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
